// File: rtl/fc_pkg.sv
// Shared types and elaboration helpers for the fully-connected layer controller.
package fc_pkg;

   typedef enum logic [1:0] {LOAD, COMPUTE, WAIT, OUT} fc_state_t;

   // Issue token carried down the read-latency pipeline.
   typedef struct packed {
      logic issue;
      logic first;
   } fc_iss_t;

   // Address/counter width for a given depth, never narrower than one bit.
   function automatic int unsigned fc_aw(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fc_ctrl_dly.sv
// Aligns accumulator strobes with memory read data: RD_LAT-deep shift of issue tokens.
module fc_ctrl_dly
   import fc_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic    clk,
   input  logic    clr_i,
   input  fc_iss_t iss_i,
   output fc_iss_t iss_o
);

   fc_iss_t pipe_q [RD_LAT];

   // Clearing empties every stage so no stale strobe survives a reset.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= iss_i;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign iss_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/fc_ctrl.sv
// Sequencer for one FC layer: loads x over a stream, runs N dot products of length M,
// and hands each result downstream before starting the next row.
module fc_ctrl
   import fc_pkg::*;
#(
   parameter int unsigned M      = 16,
   parameter int unsigned N      = 8,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned AW_X   = fc_aw(M),
   parameter int unsigned AW_W   = fc_aw(M * N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            input_valid,
   output logic            input_ready,
   output logic            output_valid,
   input  logic            output_ready,
   output logic            wr_en_x,
   output logic [AW_X-1:0] addr_x,
   output logic [AW_W-1:0] addr_w,
   output logic            clear_acc,
   output logic            en_acc
);

   localparam int unsigned NW  = fc_aw(N);
   localparam int unsigned WCW = fc_aw(RD_LAT);

   localparam logic [AW_X-1:0] K_LAST = AW_X'(M - 1);
   localparam logic [NW-1:0]   N_LAST = NW'(N - 1);
   localparam logic [WCW-1:0]  W_LOAD = WCW'(RD_LAT - 1);
   localparam logic [AW_W-1:0] ROW_STEP = AW_W'(M);

   fc_state_t       state_q, state_d;
   logic [AW_X-1:0] k_q,     k_d;
   logic [NW-1:0]   n_q,     n_d;
   logic [AW_W-1:0] base_q,  base_d;
   logic [WCW-1:0]  wcnt_q,  wcnt_d;

   fc_iss_t iss_c;
   fc_iss_t iss_dly;
   logic    accept_c;

   assign accept_c = (state_q == LOAD) && input_valid;

   // Next-state and counter logic; base_q tracks n*M so addr_w needs only an adder.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      n_d     = n_q;
      base_d  = base_q;
      wcnt_d  = wcnt_q;

      unique case (state_q)
         LOAD: begin
            if (accept_c) begin
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  state_d = COMPUTE;
               end else begin
                  k_d = k_q + AW_X'(1);
               end
            end
         end
         COMPUTE: begin
            if (k_q == K_LAST) begin
               k_d     = '0;
               wcnt_d  = W_LOAD;
               state_d = WAIT;
            end else begin
               k_d = k_q + AW_X'(1);
            end
         end
         WAIT: begin
            if (wcnt_q == '0) begin
               state_d = OUT;
            end else begin
               wcnt_d = wcnt_q - WCW'(1);
            end
         end
         OUT: begin
            if (output_ready) begin
               if (n_q == N_LAST) begin
                  n_d     = '0;
                  base_d  = '0;
                  state_d = LOAD;
               end else begin
                  n_d     = n_q + NW'(1);
                  base_d  = base_q + ROW_STEP;
                  state_d = COMPUTE;
               end
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD;
         k_q     <= '0;
         n_q     <= '0;
         base_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         n_q     <= n_d;
         base_q  <= base_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // One MAC is issued per COMPUTE cycle; the first of a row clears the accumulator.
   always_comb begin
      iss_c       = '0;
      iss_c.issue = (state_q == COMPUTE);
      iss_c.first = (state_q == COMPUTE) && (k_q == '0);
   end

   fc_ctrl_dly #(
      .RD_LAT (RD_LAT)
   ) u_dly (
      .clk   (clk),
      .clr_i (reset),
      .iss_i (iss_c),
      .iss_o (iss_dly)
   );

   // Every output is forced low while reset is held.
   assign input_ready  = (state_q == LOAD) && !reset;
   assign wr_en_x      = input_valid && input_ready;
   assign output_valid = (state_q == OUT) && !reset;
   assign addr_x       = reset ? '0 : k_q;
   assign addr_w       = reset ? '0 : (base_q + AW_W'(k_q));
   assign en_acc       = iss_dly.issue && !reset;
   assign clear_acc    = iss_dly.first && !reset;

endmodule
